// File: rtl/exponent_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exponent_add_pipe
// Purpose  : Pipelined FP-multiplier exponent adder with range and special-
//            operand classification behind a valid/ready register chain.
// Revision : 1.0 - initial release
// ============================================================================
module exponent_add_pipe #(
    parameter int EXP_W    = 8,
    parameter int BIAS     = 127,
    parameter int STAGES   = 1,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             inc_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             overflow,
    output logic             underflow,
    output logic             zero_in,
    output logic             special_in
);

    localparam int DW = EXP_W + 4;
    localparam logic [EXP_W-1:0]        c_MAXE   = {EXP_W{1'b1}};
    localparam logic signed [EXP_W+1:0] c_MAXE_S = $signed({2'b00, {EXP_W{1'b1}}});
    localparam logic signed [EXP_W+1:0] c_BIAS   = (EXP_W+2)'(BIAS);

    logic signed [EXP_W+1:0] w_raw;
    logic [EXP_W-1:0]        w_exp;
    logic                    w_ovf;
    logic                    w_unf;
    logic                    w_zero;
    logic                    w_spec;
    logic [DW-1:0]           w_cls;
    logic [STAGES-1:0]       w_load;
    logic                    w_full;

    logic [STAGES-1:0]       r_valid;
    logic [DW-1:0]           r_data [STAGES];

    // Two guard bits keep the sum of two max exponents plus carry from wrapping.
    assign w_raw = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b})
                 + $signed({{(EXP_W+1){1'b0}}, inc_exp}) - c_BIAS;

    always_comb begin
        w_exp  = w_raw[EXP_W-1:0];
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_zero = 1'b0;
        w_spec = 1'b0;
        if (exp_a == c_MAXE || exp_b == c_MAXE) begin
            w_spec = 1'b1;
            w_exp  = c_MAXE;
        end else if (exp_a == '0 || exp_b == '0) begin
            w_zero = 1'b1;
            w_exp  = '0;
        end else if (w_raw >= c_MAXE_S) begin
            w_ovf = 1'b1;
            if (SATURATE != 0) w_exp = c_MAXE - 1'b1;
        end else if (w_raw <= 0) begin
            w_unf = 1'b1;
            if (SATURATE != 0) w_exp = '0;
        end
        w_cls = {w_exp, w_ovf, w_unf, w_zero, w_spec};
    end

    // A stage may load unless it and every stage after it are full while the
    // output is stalled, so bubbles anywhere in the chain are absorbed.
    always_comb begin
        w_load = '0;
        w_full = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_full    = w_full & r_valid[i];
            w_load[i] = out_ready | ~w_full;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= w_cls;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[STAGES-1];
    assign {exp_out, overflow, underflow, zero_in, special_in} = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_exponent_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_exponent_add_pipe
// Purpose  : Self-checking bench driving three pipeline configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exponent_add_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic         iv [3];
    logic         ir [3];
    logic         inc [3];
    logic         ov [3];
    logic         ordy [3];
    logic         of [3];
    logic         uf [3];
    logic         zi [3];
    logic         sp [3];
    logic [W-1:0] ea [3];
    logic [W-1:0] eb [3];
    logic [W-1:0] eo [3];

    int checks = 0;
    int errors = 0;

    // Instance k has STAGES = k+1; instance 1 runs without saturation.
    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            exponent_add_pipe #(
                .EXP_W(W), .BIAS(127), .STAGES(k + 1), .SATURATE((k == 1) ? 0 : 1)
            ) u_dut (
                .clk(clk), .resetn(resetn),
                .in_valid(iv[k]), .in_ready(ir[k]),
                .exp_a(ea[k]), .exp_b(eb[k]), .inc_exp(inc[k]),
                .out_valid(ov[k]), .out_ready(ordy[k]),
                .exp_out(eo[k]), .overflow(of[k]), .underflow(uf[k]),
                .zero_in(zi[k]), .special_in(sp[k])
            );
        end
    endgenerate

    function automatic int sat_of(int k);
        return (k == 1) ? 0 : 1;
    endfunction

    // Result packed as exp*16 + ovf*8 + unf*4 + zero*2 + special.
    function automatic int model(int a, int b, int ic, int sat);
        int raw, e, o, u, z, s;
        raw = a + b + ic - 127;
        e = 0; o = 0; u = 0; z = 0; s = 0;
        if (a == 255 || b == 255) begin
            s = 1; e = 255;
        end else if (a == 0 || b == 0) begin
            z = 1; e = 0;
        end else if (raw >= 255) begin
            o = 1; e = sat ? 254 : (raw & 255);
        end else if (raw <= 0) begin
            u = 1; e = sat ? 0 : (raw & 255);
        end else begin
            e = raw;
        end
        return e * 16 + o * 8 + u * 4 + z * 2 + s;
    endfunction

    function automatic int obs(int k);
        return int'({eo[k], of[k], uf[k], zi[k], sp[k]});
    endfunction

    task automatic chk(string tag, int o, int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One operand pair into every instance, then verify exact latency per depth.
    task automatic single(int a, int b, int ic);
        for (int k = 0; k < 3; k++) begin
            ea[k] = W'(a); eb[k] = W'(b); inc[k] = ic[0]; iv[k] = 1'b1; ordy[k] = 1'b1;
        end
        #1;
        chk("in_ready_idle", int'(ir[2]), 1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (k + 1 == c) begin
                    chk($sformatf("valid d%0d c%0d", k, c), int'(ov[k]), 1);
                    chk($sformatf("result d%0d %0d+%0d+%0d", k, a, b, ic),
                        obs(k), model(a, b, ic, sat_of(k)));
                end else begin
                    chk($sformatf("idle d%0d c%0d", k, c), int'(ov[k]), 0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Streams operands into instance k; rnd=0 applies a fixed stall in cycles 4-7.
    task automatic stream(int k, int nops, int ncyc, bit rnd);
        int q[$];
        int idx = 0, emitted = 0, prev = 0;
        bit pending = 1'b0, stall = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            ordy[k] = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 7);
            if (!pending && idx < nops && (!rnd || $urandom_range(0, 3) != 0)) begin
                ea[k]  = W'($urandom_range(0, 255));
                eb[k]  = W'($urandom_range(0, 255));
                inc[k] = 1'($urandom_range(0, 1));
                pending = 1'b1;
            end
            iv[k] = pending;
            #1;
            if (stall) begin
                chk("stall_valid", int'(ov[k]), 1);
                chk("stall_stable", obs(k), prev);
            end
            if (!rnd && cyc >= 4 && cyc <= 7) chk("full_in_ready", int'(ir[k]), 0);
            if (ov[k] && ordy[k]) begin
                if (q.size() == 0) chk("unexpected_out", int'(ov[k]), 0);
                else begin
                    chk($sformatf("stream d%0d #%0d", k, emitted), obs(k), q.pop_front());
                    emitted++;
                end
            end
            stall = ov[k] && !ordy[k];
            prev  = obs(k);
            if (iv[k] && ir[k]) begin
                q.push_back(model(int'(ea[k]), int'(eb[k]), int'(inc[k]), sat_of(k)));
                idx++;
                pending = 1'b0;
            end
            @(posedge clk); #1;
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        chk($sformatf("emitted d%0d", k), emitted, nops);
        chk($sformatf("leftover d%0d", k), q.size(), 0);
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; ea[k] = '0; eb[k] = '0; inc[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_valid d%0d", k), int'(ov[k]), 0);
            chk($sformatf("reset_data d%0d", k), obs(k), 0);
        end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk($sformatf("ready_after_reset d%0d", k), int'(ir[k]), 1);

        single(130, 127, 0);
        single(127, 127, 1);
        single(190, 191, 0);
        single(190, 191, 1);
        single(200, 200, 0);
        single(63, 64, 0);
        single(63, 64, 1);
        single(1, 1, 0);
        single(255, 0, 0);
        single(0, 150, 0);
        single(255, 255, 1);
        single(254, 1, 0);

        stream(2, 6, 16, 1'b0);

        // Two operand pairs in flight, then an asynchronous reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            ea[k] = 8'd140; eb[k] = 8'd130; inc[k] = 1'b0; iv[k] = 1'b1; ordy[k] = 1'b0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin ea[k] = 8'd100; eb[k] = 8'd90; end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        chk("inflight_valid d1", int'(ov[1]), 1);
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_reset_valid d%0d", k), int'(ov[k]), 0);
            chk($sformatf("async_reset_data d%0d", k), obs(k), 0);
        end
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        single(150, 120, 1);

        for (int k = 0; k < 3; k++) stream(k, 150, 400, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
